// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  // Bits needed to hold any count from 0 up to and including max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_collector.sv
// Serial-to-parallel packer for bits falling out of the chain tail.
// First captured bit lands in rb_data[0]; a partial word is flushed on 'last'
// with zeros in the unused upper bits.
module ccff_rb_collector
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic              bit_in,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned RB_W = cnt_w(WORD_W);

  logic [RB_W-1:0]   rbcnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_next;
  logic              full;

  // Accumulator with the incoming bit merged in at the current position.
  always_comb begin
    acc_next = acc | (WORD_W'(bit_in) << rbcnt);
    full     = (rbcnt == RB_W'(WORD_W - 1));
  end

  // Collect tail bits and emit a word when full or at the end of the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      rbcnt    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        acc   <= '0;
        rbcnt <= '0;
      end else if (sample) begin
        if (full || last) begin
          rb_data  <= acc_next;
          rb_valid <= 1'b1;
          acc      <= '0;
          rbcnt    <= '0;
        end else begin
          acc   <= acc_next;
          rbcnt <= rbcnt + RB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Transmit end of a ccff_head -> ccff_tail configuration chain: serializes
// exactly CHAIN_LEN bits from valid/ready words and returns the bits pushed
// out of the tail as readback words.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 52,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned REM_W = cnt_w(CHAIN_LEN);
  localparam int unsigned BIT_W = cnt_w(WORD_W);

  ccff_state_e       state;
  logic [REM_W-1:0]  remaining;
  logic [BIT_W-1:0]  bitcnt;
  // Bits of the current word still waiting behind ccff_head.
  logic [WORD_W-2:0] shreg;

  logic [BIT_W-1:0]  word_bits;
  logic              last_bit;
  logic              word_end;
  logic              handshake;

  // Word length for the next capture and end-of-word/chain detection.
  always_comb begin
    word_bits = BIT_W'(WORD_W);
    if (32'(remaining) < WORD_W) begin
      word_bits = BIT_W'(remaining);
    end
    last_bit  = (remaining == REM_W'(1));
    word_end  = (bitcnt == BIT_W'(1));
    handshake = cfg_valid && cfg_ready;
  end

  // Sequencer: state, counters, tx shift register and registered outputs.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      remaining     <= '0;
      bitcnt        <= '0;
      shreg         <= '0;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= LOAD;
            remaining <= REM_W'(CHAIN_LEN);
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (handshake) begin
            state         <= SHIFT;
            shreg         <= cfg_data[WORD_W-1:1];
            bitcnt        <= word_bits;
            cfg_ready     <= 1'b0;
            ccff_head     <= cfg_data[0];
            ccff_shift_en <= 1'b1;
          end
        end

        SHIFT: begin
          shreg     <= shreg >> 1;
          bitcnt    <= bitcnt - BIT_W'(1);
          remaining <= remaining - REM_W'(1);
          if (last_bit) begin
            state         <= DONE;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end else if (word_end) begin
            state         <= LOAD;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            cfg_ready     <= 1'b1;
          end else begin
            ccff_head <= shreg[0];
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          cfg_ready     <= 1'b0;
          ccff_head     <= 1'b0;
          ccff_shift_en <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

  // Readback packer fed by the tail while the chain is advancing.
  ccff_rb_collector #(
    .WORD_W(WORD_W)
  ) u_rb (
    .clk     (prog_clk),
    .rst     (pReset),
    .clear   (state == IDLE),
    .sample  (ccff_shift_en),
    .bit_in  (ccff_tail),
    .last    (last_bit),
    .rb_data (rb_data),
    .rb_valid(rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 52-bit chain model behind the main instance,
// plus a 1-bit-chain instance driven directly.
module tb_ccff_chain_loader;

  localparam int unsigned N = 52;
  localparam int unsigned W = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         pReset;
  logic         start;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         ccff_head;
  logic         ccff_shift_en;
  logic         ccff_tail;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic         busy;
  logic         done;

  logic         start1;
  logic [W-1:0] cfg_data1;
  logic         cfg_valid1;
  logic         cfg_ready1;
  logic         head1;
  logic         shift_en1;
  logic         tail1;
  logic [W-1:0] rb_data1;
  logic         rb_valid1;
  logic         busy1;
  logic         done1;

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done)
  );

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(W)) dut1 (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start1),
    .cfg_data     (cfg_data1),
    .cfg_valid    (cfg_valid1),
    .cfg_ready    (cfg_ready1),
    .ccff_head    (head1),
    .ccff_shift_en(shift_en1),
    .ccff_tail    (tail1),
    .rb_data      (rb_data1),
    .rb_valid     (rb_valid1),
    .busy         (busy1),
    .done         (done1)
  );

  // Chain model: head enters at the top, tail is bit 0.
  logic [N-1:0] chain;
  logic         preload_req;
  logic [N-1:0] preload_val;
  assign ccff_tail = chain[0];

  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[N-1:1]};
  end

  // Event monitor, sampled on the falling edge.
  int mon_shift = 0;
  int mon_hs = 0;
  int mon_done = 0;
  int mon_busy = 0;
  int mon_done_busy = 0;
  int rb_n = 0;
  logic [W-1:0] rb_log [256];

  always @(negedge prog_clk) begin
    if (ccff_shift_en) mon_shift++;
    if (cfg_valid && cfg_ready) mon_hs++;
    if (done) mon_done++;
    if (busy) mon_busy++;
    if (done && busy) mon_done_busy++;
    if (rb_valid) begin
      rb_log[rb_n[7:0]] = rb_data;
      rb_n++;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".cfg_ready"}, 64'(cfg_ready), 64'd0);
    check({tag, ".head"},      64'(ccff_head), 64'd0);
    check({tag, ".shift_en"},  64'(ccff_shift_en), 64'd0);
    check({tag, ".rb_data"},   64'(rb_data), 64'd0);
    check({tag, ".rb_valid"},  64'(rb_valid), 64'd0);
    check({tag, ".busy"},      64'(busy), 64'd0);
    check({tag, ".done"},      64'(done), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]    preload;
    logic [6:0][7:0] words;
    int              gap;
    bit              noise;
    logic [N-1:0]    exp_chain;
    logic [6:0][7:0] exp_rb;
    int              exp_busy;
  } vec_t;

  vec_t tbl [4];

  // Offer one word: wait for ready, hold valid low for 'gap' cycles, handshake,
  // optionally spray start/cfg_valid while the word shifts out.
  task automatic send_word(input logic [7:0] w, input int gap, input bit noise,
                           input int nbits, input string tag);
    int t;
    cfg_valid = 1'b0;
    t = 0;
    while (!cfg_ready && t < 50) begin
      @(posedge prog_clk); #1;
      t++;
    end
    if (!cfg_ready) timeout_fail({tag, ".wait_ready"});
    for (int g = 0; g < gap; g++) begin
      @(negedge prog_clk);
      check($sformatf("%s.bp_ready%0d", tag, g), 64'(cfg_ready), 64'd1);
      check($sformatf("%s.bp_shift%0d", tag, g), 64'(ccff_shift_en), 64'd0);
      @(posedge prog_clk); #1;
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    @(posedge prog_clk); #1;
    cfg_valid = 1'b0;
    if (noise) begin
      cfg_data  = 8'hEE;
      cfg_valid = 1'b1;
      start     = 1'b1;
      repeat (nbits - 1) begin
        @(posedge prog_clk); #1;
      end
      cfg_valid = 1'b0;
      start     = 1'b0;
    end
  endtask

  task automatic run_load(input int k);
    int s_shift, s_hs, s_done, s_busy, s_db, s_rb, t;
    string tag;
    tag = $sformatf("load%0d", k);
    preload_val = tbl[k].preload;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    s_shift = mon_shift; s_hs = mon_hs; s_done = mon_done;
    s_busy = mon_busy; s_db = mon_done_busy; s_rb = rb_n;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    for (int w = 0; w < 7; w++)
      send_word(tbl[k].words[w], tbl[k].gap, tbl[k].noise, (w == 6) ? 4 : 8, tag);
    t = 0;
    while (mon_done == s_done && t < 100) begin
      @(posedge prog_clk); #1;
      t++;
    end
    if (mon_done == s_done) timeout_fail({tag, ".wait_done"});
    @(posedge prog_clk); #1;
    check({tag, ".shifts"},     64'(mon_shift - s_shift), 64'd52);
    check({tag, ".handshakes"}, 64'(mon_hs - s_hs), 64'd7);
    check({tag, ".done_pulses"},64'(mon_done - s_done), 64'd1);
    check({tag, ".busy_at_done"}, 64'(mon_done_busy - s_db), 64'd0);
    check({tag, ".busy_cycles"},64'(mon_busy - s_busy), 64'(tbl[k].exp_busy));
    check({tag, ".chain"},      64'(chain), 64'(tbl[k].exp_chain));
    check({tag, ".rb_count"},   64'(rb_n - s_rb), 64'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s.rb%0d", tag, i), 64'(rb_log[8'(s_rb + i)]), 64'(tbl[k].exp_rb[i]));
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".done_end"}, 64'(done), 64'd0);
  endtask

  // One-bit chain: single word, single shift, readback of the tail bit.
  task automatic run_one(input logic [7:0] d, input logic tl, input logic exp_head,
                         input logic [7:0] exp_rb, input string tag);
    start1 = 1'b1;
    @(posedge prog_clk); #1;
    start1 = 1'b0;
    cfg_data1  = d;
    cfg_valid1 = 1'b1;
    tail1      = tl;
    @(negedge prog_clk);
    check({tag, ".ready"}, 64'(cfg_ready1), 64'd1);
    check({tag, ".busy"},  64'(busy1), 64'd1);
    @(posedge prog_clk); #1;
    cfg_valid1 = 1'b0;
    @(negedge prog_clk);
    check({tag, ".shift_en"}, 64'(shift_en1), 64'd1);
    check({tag, ".head"},     64'(head1), 64'(exp_head));
    @(posedge prog_clk); #1;
    tail1 = 1'b0;
    @(negedge prog_clk);
    check({tag, ".done"},     64'(done1), 64'd1);
    check({tag, ".rb_valid"}, 64'(rb_valid1), 64'd1);
    check({tag, ".rb_data"},  64'(rb_data1), 64'(exp_rb));
    check({tag, ".busy_low"}, 64'(busy1), 64'd0);
    check({tag, ".shift_off"},64'(shift_en1), 64'd0);
    @(posedge prog_clk); #1;
    @(negedge prog_clk);
    check({tag, ".done_drop"}, 64'(done1), 64'd0);
    check({tag, ".rbv_drop"},  64'(rb_valid1), 64'd0);
    @(posedge prog_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int s;

    tbl[0].preload   = 52'hF_0123_4567_89AB;
    tbl[0].words     = {8'h0F, 8'h69, 8'h96, 8'hC3, 8'h5A, 8'h3C, 8'hA5};
    tbl[0].gap       = 0;
    tbl[0].noise     = 1'b0;
    tbl[0].exp_chain = 52'hF_6996_C35A_3CA5;
    tbl[0].exp_rb    = {8'h0F, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    tbl[0].exp_busy  = 59;

    tbl[1].preload   = 52'hF_6996_C35A_3CA5;
    tbl[1].words     = {8'hF0, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    tbl[1].gap       = 5;
    tbl[1].noise     = 1'b0;
    tbl[1].exp_chain = 52'h0_2010_0804_0201;
    tbl[1].exp_rb    = {8'h0F, 8'h69, 8'h96, 8'hC3, 8'h5A, 8'h3C, 8'hA5};
    tbl[1].exp_busy  = 94;

    tbl[2].preload   = 52'h0;
    tbl[2].words     = {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    tbl[2].gap       = 2;
    tbl[2].noise     = 1'b1;
    tbl[2].exp_chain = 52'hF_00FF_00FF_00FF;
    tbl[2].exp_rb    = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].exp_busy  = 73;

    tbl[3].preload   = 52'hA_5555_AAAA_1234;
    tbl[3].words     = {8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    tbl[3].gap       = 1;
    tbl[3].noise     = 1'b0;
    tbl[3].exp_chain = 52'hE_BC9A_7856_3412;
    tbl[3].exp_rb    = {8'h0A, 8'h55, 8'h55, 8'hAA, 8'hAA, 8'h12, 8'h34};
    tbl[3].exp_busy  = 66;

    pReset      = 1'b1;
    start       = 1'b0;
    cfg_data    = '0;
    cfg_valid   = 1'b0;
    start1      = 1'b0;
    cfg_data1   = '0;
    cfg_valid1  = 1'b0;
    tail1       = 1'b0;
    preload_req = 1'b1;
    preload_val = '0;

    repeat (3) begin
      @(posedge prog_clk); #1;
    end
    check_quiet("init");
    check("init.busy1", 64'(busy1), 64'd0);
    check("init.ready1", 64'(cfg_ready1), 64'd0);
    preload_req = 1'b0;
    pReset      = 1'b0;
    @(posedge prog_clk); #1;

    // Reset asserted for 3 cycles in the middle of a word.
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    send_word(8'hA5, 0, 1'b0, 8, "rst");
    repeat (3) begin
      @(posedge prog_clk); #1;
    end
    check("rst.mid_shift", 64'(ccff_shift_en), 64'd1);
    pReset = 1'b1;
    repeat (3) begin
      @(posedge prog_clk); #1;
    end
    check_quiet("rst.held");
    pReset = 1'b0;
    s = mon_shift;
    repeat (3) begin
      @(posedge prog_clk); #1;
    end
    check_quiet("rst.after");
    check("rst.no_shift", 64'(mon_shift - s), 64'd0);

    for (int k = 0; k < 4; k++) run_load(k);

    run_one(8'hB7, 1'b1, 1'b1, 8'h01, "c1a");
    run_one(8'h4A, 1'b0, 1'b0, 8'h00, "c1b");
    run_one(8'h02, 1'b1, 1'b0, 8'h01, "c1c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
